// File: rtl/mul_16bits_seq_pkg.sv
// Shared widths and FSM encodings for the sequential shift-and-add multiplier.
package mul_16bits_seq_pkg;

  localparam int MUL_W   = 16;
  localparam int PROD_W  = 32;
  localparam int COUNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mul_16bits_seq_adder.sv
// 16-bit adder used as the multiplier's partial-product datapath.
// cout_1 is the carry into the MSB, useful for signed overflow detection.
module full_adder_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        cout_1
);

  logic carry14;

  assign {carry14, s[14:0]} = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'd0, cin};
  assign {cout, s[15]}      = {1'b0, a[15]} + {1'b0, b[15]} + {1'b0, carry14};
  assign cout_1             = carry14;

endmodule

// File: rtl/mul_16bits_seq.sv
// Sequential unsigned multiplier: one add-and-shift per clock, start/busy/done
// handshake, registered product held until the next completion or reset.
module mul_16bits_seq
  import mul_16bits_seq_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  logic [1:0]         state;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [COUNT_W-1:0] count;

  assign addend = lo[0] ? mcand : '0;

  full_adder_16bits u_adder (
    .a      (hi),
    .b      (addend),
    .cin    (1'b0),
    .s      (sum),
    .cout   (carry),
    .cout_1 ()
  );

  // The 33-bit {carry,sum,lo} shift keeps the adder carry in hi's MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      count <= '0;
      p     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_RUN;
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            count <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          hi    <= {carry, sum[WIDTH-1:1]};
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count + COUNT_W'(1);
          if (count == COUNT_W'(WIDTH - 1)) begin
            state <= S_DONE;
            p     <= {carry, sum, lo[WIDTH-1:1]};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: doc/mul_16bits_seq.md
Name: mul_16bits_seq

Overview:
- Sequential 16x16 unsigned shift-and-add multiplier. It sits directly upstream of full_adder_16bits and drives its a/b/cin every iteration, consuming s/cout back into a partial-product register.
- One add-and-shift step per clock. A start/busy/done handshake frames each operation.
- A registered 32-bit product is presented at completion.

Parameters:
- WIDTH, 16, operand width. The product is 2*WIDTH bits and an operation takes WIDTH iterations. Only 16 is verified.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a multiply; sampled only in IDLE or DONE
- a  in  16  multiplicand; captured on the accepting edge
- b  in  16  multiplier; captured on the accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; p valid from this cycle
- p  out  32  product a*b; holds until the next accepted start

Behaviour:
- Reset (rst=1 at edge): state=IDLE, busy=0, done=0, p=0, internal hi/lo/mcand/count cleared. Applies mid-operation and aborts any run with no done pulse. rst has priority over start.
- States:
  - IDLE: start=1 -> RUN. Capture mcand=a, lo=b, hi=0, count=0.
  - RUN: one iteration per edge, 16 edges total.
  - DONE: single cycle. start=1 -> RUN with new capture (back-to-back). Otherwise -> IDLE.
- Iteration (RUN edge):
  - Adder inputs are a=hi, b=(lo[0] ? mcand : 0), cin=0. This yields {cout,s}.
  - Next state: {hi,lo} <= {cout,s,lo} >> 1, a 33-bit shift dropping the old lo[0]. count <= count+1.
- Completion: on the RUN edge with count==15, state->DONE. p is loaded with the post-shift {hi,lo} on that same edge.
- Latency: start accepted at edge E0. busy=1 for the cycles following E0..E15. done=1 and busy=0 in the cycle following E16, with p valid from then on. Throughput is one product per 17 cycles in back-to-back mode.
- start while busy (RUN) is ignored. a and b are don't-care outside the accepting edge. No queuing.
- done and busy are never high together. done is high exactly one cycle per completed operation.
- Width rules:
  - Unsigned only.
  - The product fits in 32 bits, so no overflow is possible.
  - The adder carry-out is always absorbed into hi by the shift and is never dropped.
  - cin is tied to 0.
- p is not cleared when a new start is accepted; it updates only at completion or reset.

Decomposition:
- Shared package/header: MUL_W=16, PROD_W=32, state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2, COUNT_W=4.
- One sub-module: full_adder_16bits, instantiated once as the datapath adder. The mul_16bits_seq top holds the FSM, counter, and hi/lo/mcand registers.
- The sub-module's cout_1 output is left unconnected.

Test Plan:
- rst=1 for 2 cycles with start=1 -> busy=0, done=0, p=0 throughout. No run begins.
- a=0x0001, b=0x0001, start for 1 cycle -> done pulses exactly 17 cycles after the accepting edge, p=0x00000001, busy high for 16 cycles.
- a=0x1234, b=0x1111 -> p=0x0136A974. Then a=0xFFFF, b=0xFFFF -> p=0xFFFE0001 (exercises adder cout each step).
- a=0xFFFF, b=0x0001 -> p=0x0000FFFF. a=0x0000, b=0xBEEF -> p=0x00000000 with the full 17-cycle latency.
- start=1 with new operands while busy at iteration 5 -> ignored, first product unchanged. Then hold start high through DONE with a=3, b=5 -> immediate RUN and a second done 17 cycles later with p=0x0000000F.
- rst=1 at iteration 8 of a=0x1234, b=0x1111 -> next cycle state=IDLE, busy=0, p=0, and no done pulse ever appears for the aborted run.
